// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display write sequencer.
package sevenseg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3
  } state_e;

  localparam logic [2:0] REG_V0     = 3'd0;
  localparam logic [2:0] REG_V1     = 3'd1;
  localparam logic [2:0] REG_V2     = 3'd2;
  localparam logic [2:0] REG_MASK   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam int CTRL_LZB      = 0;
  localparam int CTRL_BLINK    = 1;
  localparam int CTRL_COMMIT   = 2;
  localparam int CTRL_RATE_LSB = 4;

  localparam logic [1:0] DREG_D0   = 2'd0;
  localparam logic [1:0] DREG_D1   = 2'd1;
  localparam logic [1:0] DREG_D2   = 2'd2;
  localparam logic [1:0] DREG_MASK = 2'd3;

endpackage

// File: rtl/sevenseg_blink_timer.sv
// Blink timebase: prescaler of TICK_DIV cycles, unit counter up to RATE,
// toggling phase and a one-cycle registered tick per half-period.
module sevenseg_blink_timer #(
  parameter int TICK_DIV = 5000000,
  parameter int TICK_W   = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] rate,
  output logic       phase,
  output logic       tick
);

  logic [TICK_W-1:0] pre_q, pre_d;
  logic [3:0]        unit_q, unit_d;
  logic              phase_q, phase_d;
  logic              tick_q, tick_d;
  logic              unit_pulse;

  always_comb begin
    unit_pulse = (pre_q == TICK_W'(TICK_DIV - 1));
    pre_d      = '0;
    unit_d     = '0;
    phase_d    = 1'b1;
    tick_d     = 1'b0;
    if (en) begin
      pre_d   = unit_pulse ? '0 : pre_q + TICK_W'(1);
      unit_d  = unit_q;
      phase_d = phase_q;
      if (unit_pulse) begin
        // >= so a RATE lowered mid-count still terminates the period
        if (unit_q >= rate) begin
          unit_d  = '0;
          phase_d = ~phase_q;
          tick_d  = 1'b1;
        end else begin
          unit_d = unit_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      unit_q  <= '0;
      phase_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      unit_q  <= unit_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign phase = phase_q;
  assign tick  = tick_q;

endmodule

// File: rtl/sevenseg_ctrl.sv
// CPU-facing sequencer that bursts shadow digits/mask into the display.
// SEVENSEG_CTRL_READBACK_EN enables CPU readback of the shadow registers.
module sevenseg_ctrl
  import sevenseg_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int TICK_W   = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       seg_cs,
  output logic       seg_rw,
  output logic [1:0] seg_addr,
  output logic [7:0] seg_data,
  output logic       busy
);

  logic [2:0][7:0] v_q, v_d, s_q, s_d;
  logic [5:0]      m_q, m_d, sm_q, sm_d;
  logic            lzb_q, lzb_d, blink_q, blink_d, slzb_q, slzb_d;
  logic [3:0]      rate_q, rate_d;
  state_e          state_q, state_d;
  logic            cpend_q, cpend_d, tpend_q, tpend_d;
  logic            seg_cs_q, seg_cs_d, seg_rw_q, seg_rw_d;
  logic [1:0]      seg_addr_q, seg_addr_d;
  logic [7:0]      seg_data_q, seg_data_d;
  logic            phase, tick, wr_en, commit_req, allz;
  logic [23:0]     sval;
  logic [5:0]      lz;
  logic [7:0]      em;

  sevenseg_blink_timer #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (blink_q),
    .rate  (rate_q),
    .phase (phase),
    .tick  (tick)
  );

  assign wr_en      = cs & ~rw;
  assign commit_req = wr_en && (addr == REG_CTRL) && data_in[CTRL_COMMIT];
  assign busy       = (state_q != ST_IDLE);

  // Blank a digit only while it and every more-significant digit are zero.
  always_comb begin
    sval = {s_q[2], s_q[1], s_q[0]};
    allz = 1'b1;
    lz   = 6'h3f;
    for (int i = 5; i >= 1; i--) begin
      allz = allz & (sval[4*i +: 4] == 4'h0);
      if (slzb_q && allz) lz[i] = 1'b0;
    end
    em = {2'b00, sm_q & lz & {6{phase | ~blink_q}}};
  end

  always_comb begin
    v_d = v_q; m_d = m_q; lzb_d = lzb_q; blink_d = blink_q; rate_d = rate_q;
    s_d = s_q; sm_d = sm_q; slzb_d = slzb_q;
    state_d = state_q; cpend_d = cpend_q; tpend_d = tpend_q;
    seg_cs_d = 1'b0; seg_rw_d = 1'b1;
    seg_addr_d = seg_addr_q; seg_data_d = seg_data_q;

    if (wr_en) begin
      case (addr)
        REG_V0:   v_d[0] = data_in;
        REG_V1:   v_d[1] = data_in;
        REG_V2:   v_d[2] = data_in;
        REG_MASK: m_d = data_in[5:0];
        REG_CTRL: begin
          lzb_d   = data_in[CTRL_LZB];
          blink_d = data_in[CTRL_BLINK];
          rate_d  = data_in[CTRL_RATE_LSB +: 4];
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_req || cpend_q) begin
          state_d = ST_WR0;
          s_d     = v_q;
          sm_d    = m_q;
          slzb_d  = commit_req ? data_in[CTRL_LZB] : lzb_q;
          cpend_d = 1'b0;
          tpend_d = 1'b0;
        end else if (tick || tpend_q) begin
          state_d = ST_WR3;
          tpend_d = 1'b0;
        end
      end
      ST_WR0:  state_d = ST_WR1;
      ST_WR1:  state_d = ST_WR2;
      ST_WR2:  state_d = ST_WR3;
      default: state_d = ST_IDLE;
    endcase

    // A pending full burst rewrites the mask anyway, so it swallows ticks.
    if (state_q != ST_IDLE) begin
      if (commit_req) begin
        cpend_d = 1'b1;
        tpend_d = 1'b0;
      end else if (tick && !cpend_q) begin
        tpend_d = 1'b1;
      end
    end

    case (state_d)
      ST_WR0: begin seg_cs_d = 1'b1; seg_rw_d = 1'b0; seg_addr_d = DREG_D0;   seg_data_d = s_d[0]; end
      ST_WR1: begin seg_cs_d = 1'b1; seg_rw_d = 1'b0; seg_addr_d = DREG_D1;   seg_data_d = s_q[1]; end
      ST_WR2: begin seg_cs_d = 1'b1; seg_rw_d = 1'b0; seg_addr_d = DREG_D2;   seg_data_d = s_q[2]; end
      ST_WR3: begin seg_cs_d = 1'b1; seg_rw_d = 1'b0; seg_addr_d = DREG_MASK; seg_data_d = em;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0; m_q <= '0; lzb_q <= 1'b0; blink_q <= 1'b0; rate_q <= '0;
      s_q <= '0; sm_q <= '0; slzb_q <= 1'b0;
      state_q <= ST_IDLE; cpend_q <= 1'b0; tpend_q <= 1'b0;
      seg_cs_q <= 1'b0; seg_rw_q <= 1'b1; seg_addr_q <= '0; seg_data_q <= '0;
    end else begin
      v_q <= v_d; m_q <= m_d; lzb_q <= lzb_d; blink_q <= blink_d; rate_q <= rate_d;
      s_q <= s_d; sm_q <= sm_d; slzb_q <= slzb_d;
      state_q <= state_d; cpend_q <= cpend_d; tpend_q <= tpend_d;
      seg_cs_q <= seg_cs_d; seg_rw_q <= seg_rw_d; seg_addr_q <= seg_addr_d; seg_data_q <= seg_data_d;
    end
  end

  assign seg_cs   = seg_cs_q;
  assign seg_rw   = seg_rw_q;
  assign seg_addr = seg_addr_q;
  assign seg_data = seg_data_q;

  always_comb begin
    data_out = 8'h00;
    case (addr)
      REG_STATUS: data_out = {5'b0, phase, cpend_q, busy};
`ifdef SEVENSEG_CTRL_READBACK_EN
      REG_V0:     data_out = v_q[0];
      REG_V1:     data_out = v_q[1];
      REG_V2:     data_out = v_q[2];
      REG_MASK:   data_out = {2'b00, m_q};
      REG_CTRL:   data_out = {rate_q, 2'b00, blink_q, lzb_q};
`endif
      default:    data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sevenseg_ctrl.sv
// Bench for sevenseg_ctrl: directed scenarios plus random CPU traffic against
// a queue-based reference model of the display write stream.
module tb_sevenseg_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, cs, rw;
  logic [2:0] addr;
  logic [7:0] data_in, data_out;
  logic       seg_cs, seg_rw;
  logic [1:0] seg_addr;
  logic [7:0] seg_data;
  logic       busy;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  sevenseg_ctrl #(.TICK_DIV(TD), .TICK_W(3)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .addr(addr), .data_in(data_in),
    .data_out(data_out), .seg_cs(seg_cs), .seg_rw(seg_rw), .seg_addr(seg_addr),
    .seg_data(seg_data), .busy(busy)
  );

  // reference model: shadow bytes, snapshot, queue of display writes still owed
  logic [7:0] mv[3], ms[3];
  logic [7:0] mm, mctrl, msm;
  logic       mslzb, mcpend, mtpend, mphase, mtick;
  int         melapsed;
  int         mq[$];
  logic       ecs;
  logic [1:0] eaddr;
  logic [7:0] edata;

  int         wr_cnt;
  logic [7:0] d0q[$];

  always @(negedge clk) begin
    if (seg_cs) wr_cnt++;
    if (seg_cs && seg_addr == 2'd0) d0q.push_back(seg_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin mv[i] = 0; ms[i] = 0; end
    mm = 0; mctrl = 0; msm = 0; mslzb = 0; mcpend = 0; mtpend = 0;
    mphase = 1; mtick = 0; melapsed = 0; mq.delete();
    ecs = 0; eaddr = 0; edata = 0;
  endfunction

  function automatic logic [7:0] m_em();
    int         val = {ms[2], ms[1], ms[0]};
    logic [7:0] e = msm & 8'h3F;
    for (int i = 1; i < 6; i++)
      if (mslzb && (val >> (4 * i)) == 0) e[i] = 1'b0;
    if (mctrl[1] && !mphase) e = 8'h00;
    return e;
  endfunction

  function automatic void m_emit(input int a);
    ecs   = 1;
    eaddr = a[1:0];
    edata = (a == 3) ? m_em() : ms[a];
  endfunction

  function automatic logic [7:0] m_rd(input logic [2:0] a);
    if (a == 3'd5) return {5'b0, mphase, mcpend, ecs};
`ifdef SEVENSEG_CTRL_READBACK_EN
    if (a < 3'd3) return mv[a];
    if (a == 3'd3) return mm & 8'h3F;
    if (a == 3'd4) return mctrl & 8'hF3;
`endif
    return 8'h00;
  endfunction

  task automatic m_edge();
    logic       was_busy, commit, tk, blk;
    logic [3:0] rt;
    if (rst) begin m_reset(); return; end
    commit   = cs && !rw && addr == 3'd4 && data_in[2];
    was_busy = ecs; tk = mtick; blk = mctrl[1]; rt = mctrl[7:4];
    ecs = 0;
    if (was_busy) begin
      if (mq.size() > 0) m_emit(mq.pop_front());
      if (commit) begin mcpend = 1; mtpend = 0; end
      else if (tk && !mcpend) mtpend = 1;
    end else if (commit || mcpend) begin
      for (int i = 0; i < 3; i++) ms[i] = mv[i];
      msm = mm; mslzb = commit ? data_in[0] : mctrl[0];
      mcpend = 0; mtpend = 0;
      m_emit(0);
      mq = '{1, 2, 3};
    end else if (tk || mtpend) begin
      mtpend = 0;
      m_emit(3);
    end
    if (cs && !rw) begin
      case (addr)
        3'd0, 3'd1, 3'd2: mv[addr] = data_in;
        3'd3: mm = data_in;
        3'd4: mctrl = data_in;
        default: ;
      endcase
    end
    if (!blk) begin
      melapsed = 0; mphase = 1; mtick = 0;
    end else begin
      melapsed++;
      mtick = (melapsed % ((rt + 1) * TD)) == 0;
      if (mtick) mphase = !mphase;
    end
  endtask

  task automatic check_out();
    chk("seg_cs", seg_cs, ecs);
    chk("seg_rw", seg_rw, !ecs);
    chk("busy", busy, ecs);
    if (ecs) begin
      chk("seg_addr", seg_addr, eaddr);
      chk("seg_data", seg_data, edata);
    end
    chk("data_out", data_out, m_rd(addr));
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1; rw = 0; addr = a; data_in = d;
    cyc();
    cs = 0; rw = 1; addr = 3'd5;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b1[4];
    logic       exp_ph;
    int         nb, last, r;
    b1[0] = 8'h34; b1[1] = 8'h12; b1[2] = 8'h00; b1[3] = 8'h0F;

    rst = 1; cs = 0; rw = 1; addr = 3'd5; data_in = 0;
    m_reset();
    @(negedge clk);
    cyc(); cyc();
    rst = 0;
    chk("rst_seg_addr", seg_addr, 0);
    chk("rst_seg_data", seg_data, 0);
    chk("rst_status", data_out, 8'h04);

    // LZB burst: upper two digits blanked
    wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'h00); wr(3'd3, 8'h3F);
    wr(3'd4, 8'h05);
    for (int k = 0; k < 4; k++) begin
      chk("b1_cs", seg_cs, 1);
      chk("b1_addr", seg_addr, k);
      chk("b1_data", seg_data, b1[k]);
      if (k < 3) cyc();
    end
    cyc();
    chk("b1_idle", busy, 0);
    cyc();

    // commits while busy collapse into one extra burst
    wr_cnt = 0; d0q.delete();
    wr(3'd4, 8'h04);
    wr(3'd0, 8'h99);
    wr(3'd4, 8'h04);
    wr(3'd4, 8'h04);
    for (int k = 0; k < 14; k++) cyc();
    chk("collapse_cnt", wr_cnt, 8);
    chk("collapse_n0", d0q.size(), 2);
    chk("collapse_d0a", d0q[0], 8'h34);
    chk("collapse_d0b", d0q[1], 8'h99);

    // blink: RATE=1 -> mask-only write every 8 cycles, alternating
    wr(3'd0, 8'h56); wr(3'd1, 8'h34); wr(3'd2, 8'h12); wr(3'd3, 8'h3F);
    wr(3'd4, 8'h16);
    for (int k = 0; k < 4; k++) cyc();
    nb = 0; last = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (seg_cs) begin
        chk("blink_addr", seg_addr, 3);
        chk("blink_data", seg_data, (nb % 2) ? 8'h3F : 8'h00);
        chk("blink_phase", data_out[2], nb % 2);
        if (nb > 0) chk("blink_gap", i - last, 8);
        last = i; nb++;
      end
    end
    chk("blink_n", nb, 5);

    // tick and commit on the same edge: one burst, tick absorbed
    for (int k = 0; k < 40 && !mtick; k++) cyc();
    chk("tick_wait", mtick, 1);
    exp_ph = mphase;
    wr_cnt = 0;
    wr(3'd4, 8'h16);
    cyc(); cyc(); cyc();
    chk("tc_addr3", seg_addr, 3);
    chk("tc_d3", seg_data, exp_ph ? 8'h3F : 8'h00);
    for (int k = 0; k < 4; k++) cyc();
    chk("tc_cnt", wr_cnt, 4);

    // CTRL readback and STATUS.busy during a burst
    wr(3'd4, 8'h17);
    cs = 1; rw = 1; addr = 3'd4; #1;
`ifdef SEVENSEG_CTRL_READBACK_EN
    chk("rb_ctrl", data_out, 8'h13);
`else
    chk("rb_ctrl", data_out, 8'h00);
`endif
    addr = 3'd5; #1;
    chk("rb_busy", data_out[0], 1);
    cs = 0;
    for (int k = 0; k < 12; k++) cyc();
    wr(3'd4, 8'h00);
    for (int k = 0; k < 6; k++) cyc();

    // reset during WR1 aborts the burst
    wr(3'd4, 8'h04);
    cyc();
    chk("wr1_addr", seg_addr, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("ar_cs", seg_cs, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", seg_addr, 0);
    chk("ar_data", seg_data, 0);
    chk("ar_status", data_out, 8'h04);
    wr_cnt = 0;
    for (int k = 0; k < 6; k++) cyc();
    chk("ar_nowr", wr_cnt, 0);

    // random traffic, RATE fixed at 2 so the model's period stays valid
    wr(3'd4, 8'h20);
    for (int i = 0; i < 2000; i++) begin
      r       = $urandom_range(0, 299);
      rst     = (r == 0);
      cs      = (r >= 120);
      rw      = (r >= 225);
      addr    = 3'($urandom_range(0, 7));
      data_in = 8'($urandom);
      if (addr == 3'd4) data_in = {4'h2, data_in[3:0]};
      cyc();
    end
    rst = 0; cs = 0; rw = 1;
    for (int k = 0; k < 10; k++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sevenseg_ctrl.md
Name: sevenseg_ctrl

Overview:
- CPU-facing controller that sequences register writes into the 4-register seven-segment display peripheral.
- Peripheral registers: 0–2 are digit bytes; 3 is the digit-enable mask, bits 5:0.
- CPU writes a shadow value, mask and control. A commit snapshots them and bursts them to the display in four back-to-back write cycles.
- Adds leading-zero blanking and hardware blink by rewriting register 3 on blink ticks, with no CPU involvement.

Parameters:
- TICK_DIV, 5000000, clk cycles per blink time unit (100 ms at 50 MHz).
- TICK_W, 23, width of the prescaler counter; must satisfy 2^TICK_W > TICK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cs  in  1  CPU chip select for this block
- rw  in  1  CPU read(1)/write(0)
- addr  in  3  CPU register address
- data_in  in  8  CPU write data
- data_out  out  8  CPU read data (combinational from addr)
- seg_cs  out  1  display write strobe, registered
- seg_rw  out  1  display rw: 0 while seg_cs=1, else 1
- seg_addr  out  2  display register address
- seg_data  out  8  display write data
- busy  out  1  write sequence in progress

Behaviour:
- CPU register map, write when cs & ~rw at posedge:
  - 0/1/2: shadow value bytes V0/V1/V2 (digits 1:0 / 3:2 / 5:4).
  - 3: shadow mask M; bits 5:0 used.
  - 4: CTRL. bit0 LZB (leading-zero blank). bit1 BLINK. bit2 COMMIT (write-only, self-clearing, reads 0). bits7:4 RATE.
  - 5: STATUS, read-only: bit0 busy, bit1 commit_pending, bit2 blink phase.
  - Addresses 6–7 are ignored on write.
- Reset values:
  - V0–V2, M, CTRL = 0; phase = 1.
  - Pending flags = 0; state IDLE; busy = 0.
  - seg_cs = 0, seg_rw = 1, seg_addr = 0, seg_data = 0; prescaler and blink counters = 0.
  - Reset mid-sequence aborts immediately; no further seg_cs pulses.
- Snapshot on sequence start: S0–S2 = V0–V2, SM = M, SLZB = LZB.
  - A CTRL write with COMMIT=1 applies its own LZB/BLINK/RATE bits before the snapshot.
- Effective mask:
  - EM[5:0] = SM[5:0] & LZ[5:0] & {6{phase | ~BLINK}}; EM[7:6] = 0.
  - LZ[i] for i = 5..1 is 0 iff nibble i and all higher nibbles of {S2,S1,S0} are 0, and SLZB = 1.
  - LZ[0] = 1 always.
- FSM states: IDLE, WR0, WR1, WR2, WR3.
  - IDLE: a commit goes to WR0; else a blink tick goes to WR3 (mask-only).
  - WR0 → WR1 → WR2 → WR3 → IDLE, one cycle each.
  - In WRn: seg_cs = 1, seg_rw = 0, seg_addr = n. seg_data = S0/S1/S2/EM respectively.
- Latency: a commit sampled at posedge N gives seg_cs high during cycles N+1..N+4 and busy high N+1..N+4. IDLE is reached at N+5.
- A mask-only sequence gives 1 write cycle, at N+1.
- Commit while busy: set commit_pending. On reaching IDLE, start a full sequence next cycle with a fresh snapshot. Multiple commits collapse into one.
- Blink tick while busy: set tick_pending; it is served as mask-only after the sequence. It is dropped if a full sequence is pending, since that sequence writes EM anyway.
- Commit and tick in the same cycle: commit wins and the tick is absorbed.
- Blink timer:
  - The prescaler wraps at TICK_DIV−1 and emits a unit pulse.
  - The unit counter counts to RATE; when it reaches RATE it resets, toggles phase and raises a blink tick.
  - Half-period = (RATE+1) × TICK_DIV cycles.
  - BLINK = 0: counters held at 0, phase forced to 1, no ticks.
- CPU shadow writes never reach the display without a commit.

Optional Feature:
- Macro SEVENSEG_CTRL_READBACK_EN.
  - Defined: data_out returns V0–V2, M, and CTRL with bit2 = 0 at addresses 0–4; STATUS at 5; 0 at 6–7.
  - Undefined: data_out = STATUS at 5, 0 at all other addresses; shadow read muxes removed.

Decomposition:
- sevenseg_pkg:
  - State enum.
  - CPU register address constants (REG_V0..REG_STATUS).
  - CTRL bit indices (CTRL_LZB, CTRL_BLINK, CTRL_COMMIT, CTRL_RATE_LSB).
  - Display register indices 0–3.
- One sub-module: sevenseg_blink_timer (prescaler, unit counter, phase, tick output; inputs enable and RATE).
- LZ mask computed inline.

Test Plan:
- Reset, then write V0=0x34, V1=0x12, V2=0x00, M=0x3F, CTRL=0x05 (LZB + commit).
  - Expect seg writes (0,0x34), (1,0x12), (2,0x00), (3,0x0F) on consecutive cycles.
  - busy high for 4 cycles.
- Commit, then a second commit 2 cycles later with V0 changed to 0x99.
  - Expect the first burst unchanged.
  - One more full burst starts the cycle after IDLE, carrying 0x99.
  - A third commit mid-burst still yields only one extra burst.
- TICK_DIV=4, RATE=1, BLINK=1, M=0x3F, V=0x123456.
  - Expect a mask-only write every 8 cycles, alternating 0x00 / 0x3F; STATUS bit2 tracks phase.
- Force a blink tick in the same cycle as a COMMIT write.
  - Expect a single 4-write burst only, with register 3 = 0x3F & {6{new phase}}, then IDLE.
- Assert rst during WR1.
  - Expect seg_cs=0 the next cycle, busy=0, all registers 0, phase=1, no further writes.
- READBACK_EN: read address 4 after writing 0x17 → 0x13.
  - Without the macro, the same read returns 0x00.
  - Address 5 during a burst returns bit0=1 in both builds.
